// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stack
//  Purpose  : Parametrised return-address stack for the single-cycle CPU.
//             Ring-buffer storage with a top pointer, occupancy count,
//             full/empty status, sticky overflow/underflow flags, a
//             selectable overflow policy (drop or overwrite-oldest) and a
//             replace-top behaviour for simultaneous push+pop.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_stack #(
   parameter int AW    = 10,
   parameter int DEPTH = 8,
   parameter int WRAP  = 0,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_addr,
   input  logic          clr_err,
   output logic [AW-1:0] top,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic          underflow
);

   // Pointer width covers 0..DEPTH-1; DEPTH >= 2 keeps this at least 1 bit.
   localparam int              c_SPW        = $clog2(DEPTH);
   localparam logic [c_SPW-1:0] c_SP_LAST   = c_SPW'(DEPTH - 1);
   localparam logic [CW-1:0]   c_COUNT_FULL = CW'(DEPTH);
   localparam logic            c_WRAP       = (WRAP != 0);

   // Storage and state
   logic [AW-1:0]    r_mem [DEPTH];
   logic [c_SPW-1:0] r_sp;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;

   // Derived pointers and status
   logic [c_SPW-1:0] w_sp_inc;
   logic [c_SPW-1:0] w_sp_dec;
   logic             w_empty;
   logic             w_full;

   // Next-state decode
   logic             w_wr_en;
   logic [c_SPW-1:0] w_wr_idx;
   logic [c_SPW-1:0] w_sp_nxt;
   logic [CW-1:0]    w_count_nxt;
   logic             w_ovf_evt;
   logic             w_unf_evt;

   // Explicit wrap compares so a non-power-of-two DEPTH wraps at DEPTH-1
   // instead of at the natural binary boundary.
   assign w_sp_inc = (r_sp == c_SP_LAST) ? '0 : r_sp + c_SPW'(1);
   assign w_sp_dec = (r_sp == '0) ? c_SP_LAST : r_sp - c_SPW'(1);

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == c_COUNT_FULL);

   // All outputs come from registered state only; the PC mux may use top
   // in the same cycle it issues pop.
   assign top       = w_empty ? '0 : r_mem[r_sp];
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

   // Decode push/pop against current occupancy into write, pointer, count and error events
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_idx    = w_sp_inc;
      w_sp_nxt    = r_sp;
      w_count_nxt = r_count;
      w_ovf_evt   = 1'b0;
      w_unf_evt   = 1'b0;

      case ({push, pop})
         2'b11: begin
            if (w_empty) begin
               // Nothing to replace: behave as a plain push, but the pop
               // side still counts as an underflow.
               w_wr_en     = 1'b1;
               w_wr_idx    = w_sp_inc;
               w_sp_nxt    = w_sp_inc;
               w_count_nxt = CW'(1);
               w_unf_evt   = 1'b1;
            end else begin
               // Return-then-call collapses to overwriting the top entry.
               w_wr_en  = 1'b1;
               w_wr_idx = r_sp;
            end
         end
         2'b10: begin
            if (!w_full) begin
               w_wr_en     = 1'b1;
               w_wr_idx    = w_sp_inc;
               w_sp_nxt    = w_sp_inc;
               w_count_nxt = r_count + CW'(1);
            end else begin
               w_ovf_evt = 1'b1;
               if (c_WRAP) begin
                  // Slot after the top is the oldest entry when full.
                  w_wr_en  = 1'b1;
                  w_wr_idx = w_sp_inc;
                  w_sp_nxt = w_sp_inc;
               end
            end
         end
         2'b01: begin
            if (!w_empty) begin
               w_sp_nxt    = w_sp_dec;
               w_count_nxt = r_count - CW'(1);
            end else begin
               w_unf_evt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Pointer, count and sticky error flags; a new error event beats clr_err
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp        <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_sp        <= w_sp_nxt;
         r_count     <= w_count_nxt;
         r_overflow  <= (r_overflow  & ~clr_err) | w_ovf_evt;
         r_underflow <= (r_underflow & ~clr_err) | w_unf_evt;
      end
   end

   // Entry array is not reset; writes are suppressed while reset is asserted
   always_ff @(posedge clk) begin
      if (w_wr_en && !reset) begin
         r_mem[w_wr_idx] <= push_addr;
      end
   end

endmodule
`default_nettype wire

// File: doc/pc_stack.md
# pc_stack

Parametrised return-address stack for the single-cycle CPU: it generalises the fixed 10-bit PC stack to configurable address width and depth. It also adds full/empty status, an occupancy count, sticky overflow/underflow error flags, a selectable overflow policy and a defined simultaneous push+pop behaviour. It sits between the PC-increment mux and the PC register: `push_addr` carries the return address, and `top` feeds the stack input of the PC-select mux.

## Interface
- `AW`, 10: address (PC) width in bits, ≥1.
- `DEPTH`, 8: number of entries, ≥2, any integer (not restricted to powers of two).
- `WRAP`, 0: overflow policy. 0 = drop the push when full. 1 = circular, overwriting the oldest entry.
- `CW`, `$clog2(DEPTH+1)`: derived width of `count`; not overridden.

- `clk` in 1: the single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `push` in 1: push request (call), sampled at the rising edge.
- `pop` in 1: pop request (return), sampled at the rising edge.
- `push_addr` in AW: address written on push.
- `clr_err` in 1: clears `overflow` and `underflow` at the edge.
- `top` out AW: current top entry (combinational from stored state); 0 when empty.
- `count` out CW: number of valid entries, 0..DEPTH.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `overflow` out 1: sticky; a push occurred while full.
- `underflow` out 1: sticky; a pop occurred while empty.

## Operation
- Storage: DEPTH×AW register array, a ring top pointer `sp` (0..DEPTH-1), and `count`.
- `top` = `mem[sp]` when `count > 0`, else 0. It reflects state after the last edge, so the PC mux can use it in the same cycle as `pop`.
- Push only, not full: the entry written is `mem[sp+1 mod DEPTH]`, which becomes the new top. `count` increments.
- Push only, full, `WRAP=0`: no state change. `overflow` is set.
- Push only, full, `WRAP=1`: `sp` advances, overwriting the oldest entry. `count` stays DEPTH. `overflow` is set.
- Pop only, non-empty: `sp` decrements mod DEPTH and `count` decrements. Popped data is not cleared.
- Pop only, empty: no state change. `underflow` is set.
- Push+pop, non-empty: replace top, i.e. `mem[sp] <= push_addr`. `sp` and `count` are unchanged. No flag is set, even when full.
- Push+pop, empty: the push is performed as a plain push (`count` becomes 1). `underflow` is set.
- Flags are sticky until `clr_err` or `reset`. If `clr_err` coincides with a new error event, the flag ends set (set wins).
- Pointer arithmetic is modulo DEPTH with explicit wrap compare, not bit truncation, so non-power-of-two DEPTH works.

## Timing
- All state updates on the rising `clk` edge. Latency: push/pop take effect one edge after being sampled. `top`, `count`, `empty` and `full` are valid immediately after that edge.
- No handshake: requests are single-cycle qualifiers, and a held request repeats every cycle.
- Reset (synchronous, priority over all inputs, including mid push/pop):
  - `sp`=0, `count`=0.
  - `top`=0, `empty`=1, `full`=0.
  - `overflow`=0, `underflow`=0.
  - Array contents are not cleared.
- Status outputs are registered-state-derived: no combinational path from `push`/`pop` to any output.

## Test plan
- Reset, then DEPTH=8, AW=10: push 0x011, 0x022, 0x033 on consecutive cycles. Expect `top`=0x033, `count`=3. Then three pops: `top` reads 0x022, 0x011, 0, and `empty`=1 after the third.
- WRAP=0: push 9 distinct values. Expect `full`=1 after the 8th and `overflow`=1 after the 9th, with `top` still the 8th value. Popping 8 times returns values 8..1.
- WRAP=1: push values 1..10. Expect `count`=8, `overflow`=1, `top`=10. Popping 8 times returns 10..3, then `empty`=1.
- Pop while empty: expect `underflow`=1 and `count`=0. Then `clr_err` alone clears it. `clr_err` in the same cycle as another empty pop leaves `underflow`=1.
- Push+pop on a stack holding {0x100, 0x200}: expect `top`=push_addr, `count`=2, no flags. Push+pop when empty: expect `count`=1, `top`=push_addr, `underflow`=1.
- DEPTH=5: wrap-around of `sp` with 12 mixed push/pop operations matches a reference model. Also assert `reset` during a push and confirm all outputs return to their reset values at that edge.
